// File: rtl/rx_arbiter.sv
// rx_arbiter: merges PORT_COUNT 2-phase req/ack rx channels into one fifo push port.
// At most one grant per cycle, gated by fifo_full; the flit, write strobe and ack
// toggle all become visible right after the granting edge.
// Optional build macro: RX_ARBITER_FIXED_PRIORITY_EN
//   defined   -> fixed priority, lowest pending index wins, rr pointer pinned at 0
//   undefined -> round-robin starting at the channel after the last one served
// PORT_BITS must satisfy 2**PORT_BITS >= PORT_COUNT.
module rx_arbiter #(
  parameter int ID         = -1,
  parameter int SIZE       = 8,
  parameter int PORT_COUNT = 5,
  parameter int PORT_BITS  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PORT_COUNT-1:0]      fifo_push_req,
  output logic [PORT_COUNT-1:0]      fifo_push_ack,
  input  logic [PORT_COUNT*SIZE-1:0] fifo_push_data,
  output logic                       fifo_write,
  input  logic                       fifo_full,
  output logic [SIZE-1:0]            fifo_item_in,
  output logic [PORT_BITS-1:0]       grant_port
);

  // Distances are computed one bit wider so k + PORT_COUNT - ptr cannot overflow.
  localparam logic [PORT_BITS:0] LP_COUNT = (PORT_BITS+1)'(PORT_COUNT);
  localparam logic [PORT_BITS:0] LP_LAST  = (PORT_BITS+1)'(PORT_COUNT - 1);

  logic [PORT_COUNT-1:0] r_ack;
  logic                  r_write;
  logic [SIZE-1:0]       r_item;
  logic [PORT_BITS-1:0]  r_port;
  logic [PORT_BITS-1:0]  r_rr_ptr;

  logic [PORT_COUNT-1:0] w_pending;
  logic [PORT_COUNT-1:0] w_sel_onehot;
  logic                  w_found;
  logic                  w_grant;
  logic [PORT_BITS-1:0]  w_gnt;
  logic [SIZE-1:0]       w_gnt_data;
  logic [PORT_BITS:0]    w_ptr_ext;
  logic [PORT_BITS:0]    w_best_dist;
  logic [PORT_BITS:0]    w_dist;
  logic [PORT_BITS:0]    w_k;

  // ID only labels debug output in simulation models; keep it referenced.
  logic w_unused_id;
  assign w_unused_id = (ID < 0);

  // A channel is pending while its req and ack disagree.
  assign w_pending = fifo_push_req ^ r_ack;
  assign w_ptr_ext = {1'b0, r_rr_ptr};
  assign w_grant   = w_found && !fifo_full;

  // Pick the pending channel closest to rr_ptr in circular search order.
  always_comb begin
    w_found     = 1'b0;
    w_gnt       = '0;
    w_gnt_data  = '0;
    w_best_dist = LP_COUNT;
    w_k         = '0;
    w_dist      = '0;
    for (int k = 0; k < PORT_COUNT; k++) begin
      w_k    = (PORT_BITS+1)'(k);
      w_dist = (w_k >= w_ptr_ext) ? (w_k - w_ptr_ext) : (w_k + LP_COUNT - w_ptr_ext);
      if (w_pending[k] && (w_dist < w_best_dist)) begin
        w_found     = 1'b1;
        w_best_dist = w_dist;
        w_gnt       = PORT_BITS'(k);
        w_gnt_data  = fifo_push_data[SIZE*k +: SIZE];
      end
    end
  end

  // Per-channel ack: toggles exactly on the edge that serves that channel.
  generate
    for (genvar gi = 0; gi < PORT_COUNT; gi++) begin : g_ack
      assign w_sel_onehot[gi] = w_grant && (w_gnt == PORT_BITS'(gi));

      // Flip this channel's ack when it is granted, clearing its pending bit.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_ack[gi] <= 1'b0;
        end else if (w_sel_onehot[gi]) begin
          r_ack[gi] <= ~r_ack[gi];
        end
      end
    end
  endgenerate

  // Fifo push side: strobe for one cycle per grant, hold flit and port otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write <= 1'b0;
      r_item  <= '0;
      r_port  <= '0;
    end else begin
      r_write <= w_grant;
      if (w_grant) begin
        r_item <= w_gnt_data;
        r_port <= w_gnt;
      end
    end
  end

`ifdef RX_ARBITER_FIXED_PRIORITY_EN
  // Fixed priority: the search always starts at channel 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
    end else begin
      r_rr_ptr <= '0;
    end
  end
`else
  // Round-robin: next search starts just after the channel served, wrapping at the last port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= ({1'b0, w_gnt} == LP_LAST) ? '0 : (w_gnt + 1'b1);
    end
  end
`endif

  assign fifo_push_ack = r_ack;
  assign fifo_write    = r_write;
  assign fifo_item_in  = r_item;
  assign grant_port    = r_port;

endmodule

// File: tb/tb_rx_arbiter.sv
// tb_rx_arbiter: table-driven vectors feeding a scoreboard queue, plus hand-written
// fairness and mid-transfer reset sequences. Inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising edge.
module tb_rx_arbiter;
  localparam int SIZE = 8;
  localparam int PC   = 5;
  localparam int PB   = 4;
  localparam int NV   = 18;

  logic              clk = 1'b0;
  logic              reset;
  logic [PC-1:0]     req;
  logic [PC-1:0]     ack;
  logic [PC*SIZE-1:0] data;
  logic              wr;
  logic              full;
  logic [SIZE-1:0]   item;
  logic [PB-1:0]     port;

  always #5 clk = ~clk;

  rx_arbiter #(.ID(0), .SIZE(SIZE), .PORT_COUNT(PC), .PORT_BITS(PB)) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_push_req  (req),
    .fifo_push_ack  (ack),
    .fifo_push_data (data),
    .fifo_write     (wr),
    .fifo_full      (full),
    .fifo_item_in   (item),
    .grant_port     (port)
  );

  typedef struct {
    logic [PC-1:0]   tog;
    logic            full;
    logic            exp_wr;
    logic [PB-1:0]   exp_port;
    logic [SIZE-1:0] exp_item;
    logic [PC-1:0]   exp_ack;
  } vec_t;

  typedef struct {
    string           name;
    logic            wr;
    logic [PB-1:0]   port;
    logic [SIZE-1:0] item;
    logic [PC-1:0]   ack;
  } exp_t;

  vec_t vecs[NV];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cnt[PC];

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  task automatic push_exp(input string nm, input logic w, input logic [PB-1:0] p,
                          input logic [SIZE-1:0] it, input logic [PC-1:0] a);
    exp_t e;
    e.name = nm; e.wr = w; e.port = p; e.item = it; e.ack = a;
    exp_q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    if (exp_q.size() == 0) begin
      cmp("scoreboard_underflow", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      $display("txn %s: wr=%0d port=%0d item=%h ack=%b", e.name, wr, port, item, ack);
      cmp({e.name, ".write"}, 64'(wr), 64'(e.wr));
      cmp({e.name, ".port"},  64'(port), 64'(e.port));
      cmp({e.name, ".item"},  64'(item), 64'(e.item));
      cmp({e.name, ".ack"},   64'(ack), 64'(e.ack));
    end
  endtask

  task automatic set_vec(input int i, input logic [PC-1:0] t, input logic f, input logic w,
                         input logic [PB-1:0] p, input logic [SIZE-1:0] it, input logic [PC-1:0] a);
    vecs[i].tog = t; vecs[i].full = f; vecs[i].exp_wr = w;
    vecs[i].exp_port = p; vecs[i].exp_item = it; vecs[i].exp_ack = a;
  endtask

  // Channel data: ch0=A0 ch1=A1 ch2=5A ch3=A3 ch4=A4, held constant throughout.
  initial begin
    //            tog       full wr port  item   ack
    set_vec( 0, 5'b10011, 0, 1, 4'd0, 8'hA0, 5'b00001); // simultaneous 0,1,4
    set_vec( 1, 5'b00000, 0, 1, 4'd1, 8'hA1, 5'b00011);
    set_vec( 2, 5'b00000, 0, 1, 4'd4, 8'hA4, 5'b10011);
    set_vec( 3, 5'b00000, 0, 0, 4'd4, 8'hA4, 5'b10011); // idle, outputs hold
    set_vec( 4, 5'b00100, 0, 1, 4'd2, 8'h5A, 5'b10111); // single request on ch2
    set_vec( 5, 5'b00000, 0, 0, 4'd2, 8'h5A, 5'b10111);
    set_vec( 6, 5'b01000, 1, 0, 4'd2, 8'h5A, 5'b10111); // backpressure on ch3
    set_vec( 7, 5'b00000, 1, 0, 4'd2, 8'h5A, 5'b10111);
    set_vec( 8, 5'b00000, 1, 0, 4'd2, 8'h5A, 5'b10111);
    set_vec( 9, 5'b00000, 1, 0, 4'd2, 8'h5A, 5'b10111);
    set_vec(10, 5'b00000, 0, 1, 4'd3, 8'hA3, 5'b11111); // full released
    set_vec(11, 5'b00000, 0, 0, 4'd3, 8'hA3, 5'b11111);
    set_vec(12, 5'b00011, 0, 1, 4'd0, 8'hA0, 5'b11110); // 1->0 toggles, search wraps 4->0
    set_vec(13, 5'b00000, 0, 1, 4'd1, 8'hA1, 5'b11100);
    set_vec(14, 5'b00000, 0, 0, 4'd1, 8'hA1, 5'b11100);
    set_vec(15, 5'b10000, 1, 0, 4'd1, 8'hA1, 5'b11100); // ch4 pending behind full
`ifdef RX_ARBITER_FIXED_PRIORITY_EN
    set_vec(16, 5'b00001, 0, 1, 4'd0, 8'hA0, 5'b11101);
    set_vec(17, 5'b00000, 0, 1, 4'd4, 8'hA4, 5'b01101);
`else
    set_vec(16, 5'b00001, 0, 1, 4'd4, 8'hA4, 5'b01100); // rr=2: ch4 before ch0
    set_vec(17, 5'b00000, 0, 1, 4'd0, 8'hA0, 5'b01101);
`endif

    reset = 1'b0;
    req   = '0;
    full  = 1'b0;
    data  = 40'hA4A35AA1A0;
    for (int k = 0; k < PC; k++) cnt[k] = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset", 1'b0, '0, '0, '0);
    check_pop();
    @(negedge clk);
    reset = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      req  = req ^ vecs[i].tog;
      full = vecs[i].full;
      push_exp($sformatf("vec%0d", i), vecs[i].exp_wr, vecs[i].exp_port,
               vecs[i].exp_item, vecs[i].exp_ack);
      @(posedge clk);
      #1;
      check_pop();
    end

    // Fairness: every channel re-requests as soon as it is acknowledged
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      full = 1'b0;
      req  = ~ack;
      @(posedge clk);
      #1;
      cmp($sformatf("fair_write%0d", c), 64'(wr), 64'd1);
      if (port < PB'(PC)) cnt[port]++;
      else cmp("fair_port_range", 64'(port), 64'(PC - 1));
    end
    $display("txn fairness: grants=%0d %0d %0d %0d %0d", cnt[0], cnt[1], cnt[2], cnt[3], cnt[4]);
    for (int k = 0; k < PC; k++) begin
`ifdef RX_ARBITER_FIXED_PRIORITY_EN
      cmp($sformatf("fair_count%0d", k), 64'(cnt[k]), (k == 0) ? 64'd20 : 64'd0);
`else
      cmp($sformatf("fair_count%0d", k), 64'(cnt[k]), 64'd4);
`endif
    end
    @(negedge clk);
    req = ack;  // withdraw all requests
    @(posedge clk);
    #1;
    cmp("fair_drain_write", 64'(wr), 64'd0);

    // Reset mid-transfer: build ack=10110 with fifo_write=1, then drop reset
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    req = 5'b10110;
    push_exp("mid1", 1'b1, 4'd1, 8'hA1, 5'b00010);
    push_exp("mid2", 1'b1, 4'd2, 8'h5A, 5'b00110);
    push_exp("mid3", 1'b1, 4'd4, 8'hA4, 5'b10110);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_pop();
    end
    #2;
    reset = 1'b0;
    req   = '0;
    #1;
    push_exp("rst_async", 1'b0, '0, '0, '0);
    check_pop();
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      push_exp($sformatf("post_rst%0d", c), 1'b0, '0, '0, '0);
      @(posedge clk);
      #1;
      check_pop();
    end
    @(negedge clk);
    req = 5'b01000;
    push_exp("post_rst_req", 1'b1, 4'd3, 8'hA3, 5'b01000);
    push_exp("post_rst_idle", 1'b0, 4'd3, 8'hA3, 5'b01000);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_pop();
    end

    cmp("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
